// File: rtl/pes_crc16_checker.sv
// -----------------------------------------------------------------------------
// pes_crc16_checker
//
// Receive-side CRC-16 checker for frames whose last two bytes are the CRC
// appended by the byte-parallel generator (high byte first). The CRC
// (poly 0x8005, MSB-first, no reflection, no final XOR) is recomputed over the
// whole frame, including the two CRC bytes. A good frame leaves a zero
// remainder. The payload is forwarded with the two CRC bytes stripped.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   load         frame start strobe; accepted in any state, aborts a frame
//   d_valid      d_in carries a frame byte this cycle
//   d_last       with d_valid: this byte is the final (CRC low) byte
//   d_in         frame byte, bit 7 processed first
//   d_out        forwarded payload byte
//   d_out_valid  d_out valid this cycle
//   done         one-cycle pulse, verdict outputs valid
//   crc_ok       held verdict: remainder zero and at least 3 frame bytes
//   crc_err      held verdict: complement of crc_ok
//   crc_rem      held final remainder
//   frame_len    held payload byte count (frame bytes - 2, saturating)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for load; d_valid ignored
// RECV   | accepting frame bytes, updating CRC, forwarding delayed payload
// RESULT | single cycle after the d_last byte; done is high
// -----------------------------------------------------------------------------
module pes_crc16_checker #(
  parameter int unsigned CNT_W = 16,
  parameter logic [15:0] INIT  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             d_valid,
  input  logic             d_last,
  input  logic [7:0]       d_in,
  output logic [7:0]       d_out,
  output logic             d_out_valid,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [15:0]      crc_rem,
  output logic [CNT_W-1:0] frame_len
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [15:0]      POLY      = 16'h8005;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_THREE = CNT_W'(3);

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      crc_reg;
  logic [15:0]      crc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       buf_old;
  logic [7:0]       buf_new;
  logic [1:0]       buf_cnt;
  logic             accept;
  logic             ok_nxt;

  // One byte of the MSB-first CRC update; identical to the generator.
  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0]  d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (r[15]) r = {r[14:0], 1'b0} ^ POLY;
      else       r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // load has priority over a byte presented in the same cycle.
  assign accept  = (state == RECV) && d_valid && !load;
  assign crc_nxt = crc_byte(crc_reg, d_in);
  assign cnt_nxt = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);
  assign ok_nxt  = (cnt_nxt >= CNT_THREE) && (crc_nxt == 16'h0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load) state_nxt = RECV;
      end
      RECV: begin
        if (load)                     state_nxt = RECV;
        else if (d_valid && d_last)   state_nxt = RESULT;
      end
      RESULT: begin
        state_nxt = load ? RECV : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The two most recent bytes are held back; only when a third arrives is the
  // oldest known to be payload. Whatever sits in the buffer at d_last is CRC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_reg     <= INIT;
      cnt         <= '0;
      buf_old     <= 8'h00;
      buf_new     <= 8'h00;
      buf_cnt     <= 2'd0;
      d_out       <= 8'h00;
      d_out_valid <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      crc_rem     <= 16'h0000;
      frame_len   <= '0;
    end else begin
      d_out_valid <= 1'b0;
      done        <= 1'b0;
      if (load) begin
        crc_reg <= INIT;
        cnt     <= '0;
        buf_cnt <= 2'd0;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (accept) begin
        crc_reg <= crc_nxt;
        cnt     <= cnt_nxt;
        case (buf_cnt)
          2'd0: begin
            buf_old <= d_in;
            buf_cnt <= 2'd1;
          end
          2'd1: begin
            buf_new <= d_in;
            buf_cnt <= 2'd2;
          end
          default: begin
            d_out       <= buf_old;
            d_out_valid <= 1'b1;
            buf_old     <= buf_new;
            buf_new     <= d_in;
          end
        endcase
        if (d_last) begin
          done      <= 1'b1;
          crc_rem   <= crc_nxt;
          frame_len <= (cnt_nxt >= CNT_TWO) ? (cnt_nxt - CNT_TWO) : '0;
          crc_ok    <= ok_nxt;
          crc_err   <= !ok_nxt;
        end
      end
    end
  end

endmodule
